// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;
  localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_DW-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO of fetched words.
// Slot e0 is always the head, so the head is a plain register.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter logic [FETCH_AW-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  occ_e state, state_n;
  fetch_entry_t e0, e1, e0_n, e1_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      e0 <= '{pc: RESET_PC, instr: NOP_INSTR};
      e1 <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else begin
      state <= state_n;
      e0 <= e0_n;
      e1 <= e1_n;
    end
  end

  always_comb begin
    state_n = state;
    e0_n = e0;
    e1_n = e1;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            e0_n = din;
            state_n = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            e0_n = din;
          end else if (push) begin
            e1_n = din;
            state_n = FULL;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (push && pop) begin
            e0_n = e1;
            e1_n = din;
          end else if (pop) begin
            e0_n = e1;
            state_n = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign head = e0;
  assign count = state;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register plus 2-deep buffer toward decode.
// Redirect flushes the buffer and wins over push/pop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FETCH_AW,
  parameter int DATA_WIDTH = FETCH_DW,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pc_plus4
);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [1:0] count;
  logic pop, push, fifo_pop;
  fetch_entry_t din, head;
  logic unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  assign out_valid = (count != 2'd0);
  assign pop = out_valid & out_ready;
  assign fifo_pop = pop & ~redirect_valid;
  assign push = ~redirect_valid & ((count != 2'd2) | pop);

  assign din = '{pc: pc, instr: imem_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + ADDRESS_WIDTH'(4);
    end
  end

  fetch_fifo #(
    .RESET_PC(RESET_PC)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (fifo_pop),
    .flush(redirect_valid),
    .din  (din),
    .head (head),
    .count(count)
  );

  assign imem_addr = pc;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign out_pc_plus4 = head.pc + ADDRESS_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with ROM mem[a] = A000_0000 | a.
// Vector table plus hand sequences for backpressure and async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int total = 0;
  int passed = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4)
  );

  always #5 clk = ~clk;

  assign imem_data = 32'hA000_0000 | imem_addr;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic        chk_head;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_plus4;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        was_stall;

    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    //        rst  rdy rv  rpc           val hd  pc            instr         plus4         addr
    vecs[0]  = '{1, 1, 0, 32'h0,        0, 1, 32'h0,        32'h13,       32'h4,        32'h0};
    vecs[1]  = '{0, 1, 0, 32'h0,        0, 1, 32'h0,        32'h13,       32'h4,        32'h0};
    vecs[2]  = '{0, 1, 0, 32'h0,        1, 1, 32'h0,        32'hA0000000, 32'h4,        32'h4};
    vecs[3]  = '{0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hA0000004, 32'h8,        32'h8};
    vecs[4]  = '{0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hA0000004, 32'h8,        32'hC};
    vecs[5]  = '{0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hA0000004, 32'h8,        32'hC};
    vecs[6]  = '{0, 1, 1, 32'h40,       1, 1, 32'h4,        32'hA0000004, 32'h8,        32'hC};
    vecs[7]  = '{0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h40};
    vecs[8]  = '{0, 1, 1, 32'h13,       1, 1, 32'h40,       32'hA0000040, 32'h44,       32'h44};
    vecs[9]  = '{0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        32'h0,        32'h0,        32'h10};
    vecs[10] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFC};
    vecs[11] = '{0, 1, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0};
    vecs[12] = '{0, 1, 0, 32'h0,        1, 1, 32'h0,        32'hA0000000, 32'h4,        32'h4};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      out_ready = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #1;
      check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d out_instr", i), out_instr, vecs[i].e_instr);
        check($sformatf("v%0d out_pc_plus4", i), out_pc_plus4, vecs[i].e_plus4);
      end
      step();
    end
    redirect_valid = 1'b0;

    // Backpressure from reset: fill, then drain in order.
    out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    #1;
    check("bp addr held", imem_addr, 32'h8);
    check("bp valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp drain %0d", k), out_pc, 32'(k * 4));
      step();
      #1;
    end

    // Random ready pattern: strict order and stall stability.
    do_reset();
    exp_pc = 32'h0;
    was_stall = 1'b0;
    hold_pc = '0;
    hold_instr = '0;
    for (int c = 0; c < 60; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (was_stall) begin
        check("stall pc stable", out_pc, hold_pc);
        check("stall instr stable", out_instr, hold_instr);
      end
      if (out_valid && out_ready) begin
        check("order pc", out_pc, exp_pc);
        check("order instr", out_instr, 32'hA000_0000 | exp_pc);
        exp_pc = exp_pc + 32'h4;
      end
      was_stall = out_valid && !out_ready;
      hold_pc = out_pc;
      hold_instr = out_instr;
      step();
    end
    check("order progressed", 32'(exp_pc > 32'h20), 32'h1);

    // Fill to FULL with PC=0x20, then async reset pulse mid-cycle.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h18;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    #1;
    check("pre-rst addr", imem_addr, 32'h20);
    check("pre-rst valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 32'h0);
    check("async rst addr", imem_addr, 32'h0);
    check("async rst instr", out_instr, 32'h13);
    #1;
    rst = 1'b0;
    step();
    #1;
    check("resume valid", 32'(out_valid), 32'h1);
    check("resume pc", out_pc, 32'h0);
    check("resume addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of every PC/address signal.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 imem_addr  output  ADDRESS_WIDTH  byte address to the instruction memory, equals the PC register.
REQ-008 imem_data  input  DATA_WIDTH  instruction word, combinational from imem_addr, same cycle.
REQ-009 redirect_valid  input  1  taken branch/jump; flushes the fetch stage.
REQ-010 redirect_pc  input  ADDRESS_WIDTH  new fetch address.
REQ-011 out_valid  output  1  head entry valid toward decode.
REQ-012 out_ready  input  1  decode accepts head entry this cycle.
REQ-013 out_instr  output  DATA_WIDTH  head instruction word.
REQ-014 out_pc  output  ADDRESS_WIDTH  address of out_instr.
REQ-015 out_pc_plus4  output  ADDRESS_WIDTH  out_pc + 4, modulo 2^ADDRESS_WIDTH.

Function
REQ-016 The PC register SHALL drive imem_addr directly; no combinational path from any input to imem_addr.
REQ-017 A 2-entry FIFO of {pc, instr} SHALL buffer fetched words; occupancy 0/1/2 (EMPTY/ONE/FULL) is the block state.
REQ-018 pop = out_valid & out_ready; push (fetch) = !redirect_valid & (occupancy<2 | pop).
REQ-019 On push: entry {PC, imem_data} SHALL be written to FIFO tail and PC <= PC+4, modulo 2^ADDRESS_WIDTH (0xFFFFFFFC wraps to 0x0).
REQ-020 Without push, PC SHALL hold.
REQ-021 Transitions: EMPTY->ONE on push; ONE->FULL on push & !pop; FULL->ONE on pop & !push; push&pop leaves occupancy unchanged; ONE->EMPTY on pop & !push.
REQ-022 Redirect priority: when redirect_valid=1, FIFO SHALL empty, pop SHALL be discarded, no push, and PC <= {redirect_pc[AW-1:2], 2'b00}.
REQ-023 Latency: word fetched at cycle N SHALL appear on out_* at cycle N+1 when FIFO was empty.
REQ-024 out_valid SHALL be 1 exactly when occupancy>0; out_* SHALL come from registers only.
REQ-025 out_instr/out_pc/out_pc_plus4 SHALL hold stable while out_valid=1 & out_ready=0.
REQ-026 FIFO order SHALL be strict; no entry lost or duplicated under any out_ready pattern.

Reset
REQ-027 While rst=1: PC=RESET_PC, occupancy=EMPTY, out_valid=0, out_instr=32'h00000013 (NOP), out_pc=RESET_PC, out_pc_plus4=RESET_PC+4.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously).
REQ-029 First push SHALL occur on the first rising edge with rst=0.

Structure
REQ-030 Package fetch_pkg SHALL hold ADDRESS_WIDTH/DATA_WIDTH defaults, RESET_PC, NOP encoding and typedef fetch_entry_t {pc, instr}.
REQ-031 Sub-module fetch_fifo (2-entry, fetch_entry_t, push/pop/flush, count) SHALL hold the buffer; PC logic stays in fetch_unit.

Verification (bench ROM: mem[a] = 32'hA000_0000 | a)
REQ-032 Reset release, out_ready=1 -> cycle 0 imem_addr=0x0, out_valid=0; cycle 1 out_pc=0x0, out_instr=0xA0000000; cycle 2 out_pc=0x4.
REQ-033 out_ready=0 for 5 cycles from reset -> occupancy 2, imem_addr holds 0x8; then out_ready=1 -> out_pc 0x0, 0x4, 0x8, 0xC consecutively.
REQ-034 FULL, redirect_valid=1, redirect_pc=0x40, out_ready=1 -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40, out_instr=0xA0000040.
REQ-035 redirect_pc=0x13 -> imem_addr=0x10; redirect_pc=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000, out_pc_plus4 of first =0x0.
REQ-036 rst pulsed mid-cycle while FULL at PC=0x20 -> out_valid=0 and imem_addr=0x0 before next edge; resumes at 0x0 after release.
